// File: rtl/sopc_be_pkg.sv
// ============================================================================
// sopc_be_pkg : memory geometry constants and read-master FSM state encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package sopc_be_pkg;

  localparam int MEM_DATA_W = 1024;
  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DEPTH  = 313;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sopc_be_mem_read_master_if.sv
// ============================================================================
// sopc_be_mem_read_master_if : command, memory-port and stream bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface sopc_be_mem_read_master_if
  import sopc_be_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [ADDR_W-1:0]     cmd_len;

  logic [ADDR_W-1:0]     mem_address;
  logic                  mem_chipsel;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_byteen;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_clken;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_last;

  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
    output cmd_ready, mem_address, mem_chipsel, mem_write, mem_byteen,
           mem_wdata, mem_clken, out_valid, out_data, out_last,
           busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
    input  cmd_ready, mem_address, mem_chipsel, mem_write, mem_byteen,
           mem_wdata, mem_clken, out_valid, out_data, out_last,
           busy, done, err
  );

endinterface

`default_nettype wire

// File: rtl/sopc_be_sync_fifo.sv
// ============================================================================
// sopc_be_sync_fifo : synchronous FIFO with a registered output stage
// Revision 1.0
// ============================================================================
`default_nettype none

module sopc_be_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_st_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic w_pop;
  logic w_load;
  logic w_from_st;
  logic w_bypass;
  logic w_st_wr;

  // The output register refills from storage first, or directly from push when storage is empty.
  assign w_pop     = pop & r_out_valid;
  assign w_load    = ~r_out_valid | w_pop;
  assign w_from_st = w_load & (r_st_cnt != '0);
  assign w_bypass  = w_load & (r_st_cnt == '0) & push;
  assign w_st_wr   = push & ~w_bypass;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_st_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_load) begin
        if (w_from_st) begin
          r_out_data <= r_mem[r_rd_ptr];
        end else if (push) begin
          r_out_data <= push_data;
        end
        r_out_valid <= w_from_st | push;
      end
      if (w_st_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_from_st) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_st_cnt <= r_st_cnt + CNT_W'(w_st_wr) - CNT_W'(w_from_st);
    end
  end

  always_ff @(posedge clk) begin
    if (w_st_wr) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = r_st_cnt + CNT_W'(r_out_valid);
  assign full      = (count >= CNT_W'(DEPTH));
  assign empty     = (count == '0);

endmodule

`default_nettype wire

// File: rtl/sopc_be_mem_read_master.sv
// ============================================================================
// sopc_be_mem_read_master : credit-limited block reader for the on-chip RAM s1 port
// Revision 1.0
// ============================================================================
`default_nettype none

module sopc_be_mem_read_master
  import sopc_be_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  sopc_be_mem_read_master_if.master   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int USE_W = CNT_W + 1;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rem;
  logic              r_chipsel;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_fifo_valid;
  logic [DATA_W:0]   w_fifo_out;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic [USE_W-1:0]  w_next_used;
  logic              w_credit_ok;
  logic              w_cmd_fire;
  logic [ADDR_W:0]   w_cmd_end;
  logic              w_cmd_bad;
  logic              w_unused;

  sopc_be_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_inflight),
    .push_data ({r_inflight_last, bus.mem_rdata}),
    .pop       (bus.out_ready),
    .out_valid (w_fifo_valid),
    .out_data  (w_fifo_out),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign w_unused = &{1'b0, w_fifo_full, w_fifo_empty};
  assign w_pop    = w_fifo_valid & bus.out_ready;

  // Occupancy (buffered + in flight) as it will stand next cycle, so chipsel can stay registered.
  assign w_next_used = USE_W'(w_fifo_count) + USE_W'(r_inflight)
                     + USE_W'(r_chipsel) - USE_W'(w_pop);
  assign w_credit_ok = (w_next_used < USE_W'(FIFO_DEPTH));

  assign w_cmd_fire = bus.cmd_valid & r_cmd_ready;
  assign w_cmd_end  = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign w_cmd_bad  = (bus.cmd_len == '0) || (w_cmd_end > (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_rem           <= '0;
      r_chipsel       <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_cmd_ready     <= 1'b1;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_inflight      <= r_chipsel;
      r_inflight_last <= r_chipsel & (r_rem == ADDR_W'(1));
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            if (w_cmd_bad) begin
              r_err <= 1'b1;
            end else begin
              r_addr      <= bus.cmd_addr;
              r_rem       <= bus.cmd_len;
              r_chipsel   <= 1'b1;
              r_busy      <= 1'b1;
              r_cmd_ready <= 1'b0;
              r_state     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_chipsel) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == ADDR_W'(1)) begin
              r_chipsel <= 1'b0;
              r_state   <= ST_DRAIN;
            end else begin
              r_chipsel <= w_credit_ok;
            end
          end else begin
            r_chipsel <= w_credit_ok;
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_fifo_out[DATA_W]) begin
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.mem_address = r_addr;
  assign bus.mem_chipsel = r_chipsel;
  assign bus.mem_write   = 1'b0;
  assign bus.mem_byteen  = '1;
  assign bus.mem_wdata   = '0;
  assign bus.mem_clken   = 1'b1;
  assign bus.out_valid   = w_fifo_valid;
  assign bus.out_data    = w_fifo_out[DATA_W-1:0];
  assign bus.out_last    = w_fifo_out[DATA_W];
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sopc_be_mem_read_master.sv
// ============================================================================
// tb_sopc_be_mem_read_master : directed vector bench with a 1-cycle-latency RAM model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sopc_be_mem_read_master;

  localparam int DW = 1024;
  localparam int AW = 9;
  localparam int FD = 4;

  typedef struct {
    int addr;
    int len;
    int mode;
    bit bad;
    int poke;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   n_issue = 0;
  int   occ     = 0;
  int   max_occ = 0;
  vec_t vt [11];

  sopc_be_mem_read_master_if bus ();

  sopc_be_mem_read_master #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .DEPTH      (313),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input int a);
    return {(DW/32){a[31:0]}};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_chipsel) bus.mem_rdata <= word_of(int'(bus.mem_address));
    else                 bus.mem_rdata <= {(DW/32){32'hDEADBEEF}};
  end

  // Occupancy model: words issued but not yet taken by the consumer.
  always @(posedge clk) begin
    if (reset) begin
      occ     = 0;
      max_occ = 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) max_occ = 0;
      occ = occ + (bus.mem_chipsel ? 1 : 0) - ((bus.out_valid && bus.out_ready) ? 1 : 0);
      if (occ > max_occ) max_occ = occ;
      if (bus.mem_chipsel) n_issue = n_issue + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got ..%h expected ..%h", nm, act[63:0], exp[63:0]);
    end
  endtask

  function automatic bit rdy(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return cyc[0];
      default: return ((cyc % 12) < 8) ? 1'b0 : cyc[0];
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready,   1);
    chk({tag, "_chipsel"},   bus.mem_chipsel, 0);
    chk({tag, "_address"},   bus.mem_address, 0);
    chk({tag, "_out_valid"}, bus.out_valid,   0);
    chk({tag, "_out_last"},  bus.out_last,    0);
    chk({tag, "_busy"},      bus.busy,        0);
    chk({tag, "_done"},      bus.done,        0);
    chk({tag, "_err"},       bus.err,         0);
  endtask

  // Issues one command and returns positioned in its done cycle (or after the err pulse).
  task automatic run_cmd(input int addr, input int len, input int mode, input bit bad, input int poke);
    int base;
    int k;
    int cyc;
    int first_v;
    bit hold_chk;
    bit r;
    logic [DW-1:0] held;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    base = n_issue;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = AW'(len);
    bus.out_ready = rdy(mode, 0);
    tick();
    if (poke > 0) begin
      bus.cmd_addr = AW'(300);
      bus.cmd_len  = AW'(5);
    end else begin
      bus.cmd_valid = 1'b0;
    end
    chk("done_low_c1", bus.done, 0);
    if (bad) begin
      chk("err_pulse", bus.err, 1);
      chk("err_busy", bus.busy, 0);
      chk("err_cmd_ready", bus.cmd_ready, 1);
      chk("err_chipsel", bus.mem_chipsel, 0);
      bus.cmd_valid = 1'b0;
      tick();
      chk("err_one_cycle", bus.err, 0);
      tick();
      chk("err_no_issue", 64'(n_issue - base), 0);
      return;
    end
    chk("acc_err_low", bus.err, 0);
    chk("acc_busy", bus.busy, 1);
    chk("acc_cmd_ready", bus.cmd_ready, 0);
    chk("first_chipsel", bus.mem_chipsel, 1);
    chk("first_address", bus.mem_address, 64'(addr));
    k = 0;
    cyc = 1;
    first_v = -1;
    hold_chk = 1'b0;
    held = '0;
    while (k < len && cyc < 4000) begin
      if (poke > 0 && cyc <= poke) chk("cmd_ready_busy", bus.cmd_ready, 0);
      else bus.cmd_valid = 1'b0;
      r = rdy(mode, cyc);
      if (hold_chk && bus.out_valid) chk_word("hold_data", bus.out_data, held);
      hold_chk = 1'b0;
      if (bus.out_valid && first_v < 0) first_v = cyc;
      if (bus.out_valid && r) begin
        chk_word("word_data", bus.out_data, word_of(addr + k));
        chk("word_last", bus.out_last, (k == len - 1) ? 1 : 0);
        k++;
      end else if (bus.out_valid) begin
        held = bus.out_data;
        hold_chk = 1'b1;
      end
      bus.out_ready = r;
      tick();
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    if (k < len) begin
      chk("stream_timeout_words", 64'(k), 64'(len));
      return;
    end
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_cmd_ready", bus.cmd_ready, 1);
    chk("done_out_valid", bus.out_valid, 0);
    chk("issue_count", 64'(n_issue - base), 64'(len));
    chk("occ_bound", (max_occ <= FD) ? 1 : 0, 1);
    if (mode == 0) begin
      chk("first_valid_cycle", 64'(first_v), 3);
      chk("done_cycle", 64'(cyc), 64'(len + 3));
    end
    if (mode == 2) chk("occ_full_credit", 64'(max_occ), FD);
  endtask

  initial begin
    vt[0]  = '{addr: 0,   len: 4,   mode: 0, bad: 1'b0, poke: 0};
    vt[1]  = '{addr: 309, len: 4,   mode: 0, bad: 1'b0, poke: 0};
    vt[2]  = '{addr: 310, len: 4,   mode: 0, bad: 1'b1, poke: 0};
    vt[3]  = '{addr: 5,   len: 0,   mode: 0, bad: 1'b1, poke: 0};
    vt[4]  = '{addr: 10,  len: 16,  mode: 2, bad: 1'b0, poke: 0};
    vt[5]  = '{addr: 100, len: 7,   mode: 1, bad: 1'b0, poke: 3};
    vt[6]  = '{addr: 0,   len: 313, mode: 0, bad: 1'b0, poke: 0};
    vt[7]  = '{addr: 312, len: 1,   mode: 0, bad: 1'b0, poke: 0};
    vt[8]  = '{addr: 0,   len: 314, mode: 0, bad: 1'b1, poke: 0};
    vt[9]  = '{addr: 511, len: 1,   mode: 0, bad: 1'b1, poke: 0};
    vt[10] = '{addr: 200, len: 20,  mode: 2, bad: 1'b0, poke: 0};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_vals("por");
    chk("tie_write", bus.mem_write, 0);
    chk("tie_clken", bus.mem_clken, 1);
    chk("tie_byteen", {63'd0, &bus.mem_byteen}, 1);
    chk("tie_wdata", {63'd0, |bus.mem_wdata}, 0);
    tick();

    for (int i = 0; i < 11; i++) begin
      run_cmd(vt[i].addr, vt[i].len, vt[i].mode, vt[i].bad, vt[i].poke);
      tick();
    end

    // Reset in cycle 5 of a stalled len=20 read, then a fresh command.
    bus.out_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(0);
    bus.cmd_len   = AW'(20);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midrst");
    tick();
    run_cmd(0, 2, 0, 1'b0, 0);
    tick();

    // Back-to-back single-word commands; the second starts in the first's done cycle.
    run_cmd(40, 1, 0, 1'b0, 0);
    run_cmd(41, 1, 0, 1'b0, 0);
    tick();
    chk("b2b_done_cleared", bus.done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
